// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART peripheral.
// Holds the receive FSM state type, the parity/stop-bit encodings used by
// the status register fields, both data-length types (legacy 2-bit enum and
// the widened 4-bit length), and a 3-input majority helper.
package uart_pkg;

    localparam int unsigned UART_MAX_DATA_BITS = 9;

    typedef enum logic {
        UART_PARITY_EVEN = 1'b0,
        UART_PARITY_ODD  = 1'b1
    } uart_parity_mode_t;

    typedef enum logic {
        UART_STOP1 = 1'b0,
        UART_STOP2 = 1'b1
    } uart_stop_bits_t;

    // Legacy fixed receive path length encoding (5..8 bits).
    typedef enum logic [1:0] {
        UART_DATA_BITS_5 = 2'd0,
        UART_DATA_BITS_6 = 2'd1,
        UART_DATA_BITS_7 = 2'd2,
        UART_DATA_BITS_8 = 2'd3
    } uart_data_bits_t;

    // Widened length, holds the bit count directly (5..9).
    typedef logic [3:0] uart_data_length_t;

    typedef enum logic [2:0] {
        RX_IDLE       = 3'd0,
        RX_START      = 3'd1,
        RX_DATA       = 3'd2,
        RX_PARITY     = 3'd3,
        RX_STOP       = 3'd4,
        RX_BREAK_WAIT = 3'd5
    } uart_rx_state_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
// Ports:
//   clk_i, rst_n_i   clock, synchronous active-low reset
//   enable_i         counter runs while high, held cleared while low
//   clock_divider_i  tick_o pulses every clock_divider_i+1 enabled cycles
//   tick_o           single-cycle tick
module uart_baud_tick #(
    parameter int unsigned DIVIDER_WIDTH = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     enable_i,
    input  logic [DIVIDER_WIDTH-1:0] clock_divider_i,
    output logic                     tick_o
);

    logic [DIVIDER_WIDTH-1:0] count;

    assign tick_o = enable_i && (count == clock_divider_i);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !enable_i) begin
            count <= '0;
        end else if (count == clock_divider_i) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: oversampling UART receiver with majority voting, parity,
// framing-error and break detection, and a valid/ready output stage.
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   enable_i            receiver enable; low aborts any frame in progress
//   rx_i                asynchronous serial line, idle high
//   clock_divider_i     oversample tick every clock_divider_i+1 cycles
//   data_bits_i         data length 5..MAX_DATA_BITS (clamped)
//   parity_enable_i, parity_mode_i, stop_bits_i   frame format
//   data_o              received word, zero-extended
//   valid_o / ready_i   output handshake; parity_error_o, frame_error_o qualified by valid_o
//   overrun_o           pulse: word replaced before it was accepted
//   break_o             pulse: break detected
//   busy_o              frame in progress
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned DIVIDER_WIDTH = 15,
    parameter int unsigned MAX_DATA_BITS = UART_MAX_DATA_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     enable_i,
    input  logic                     rx_i,
    input  logic [DIVIDER_WIDTH-1:0] clock_divider_i,
    input  logic [3:0]               data_bits_i,
    input  logic                     parity_enable_i,
    input  logic                     parity_mode_i,
    input  logic                     stop_bits_i,
    output logic [MAX_DATA_BITS-1:0] data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     parity_error_o,
    output logic                     frame_error_o,
    output logic                     overrun_o,
    output logic                     break_o,
    output logic                     busy_o
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SAMP_0    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] SAMP_1    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] SAMP_2    = TW'(OVERSAMPLE / 2 + 1);

    logic                     rx_meta, rx_sync;
    logic                     armed;
    uart_rx_state_t           state;
    logic                     tick, bit_end, bit_val;
    logic [TW-1:0]            tick_cnt;
    logic [2:0]               samples;
    logic [3:0]               bit_cnt;
    logic                     stop_cnt;
    uart_data_length_t        data_bits_q, len_clamped;
    logic                     par_en_q;
    uart_parity_mode_t        par_mode_q;
    uart_stop_bits_t          stop_q;
    logic [MAX_DATA_BITS-1:0] shift_q;
    logic                     parity_bit_q, first_stop_q, stop_err_q;
    logic                     last_stop, first_stop_now, frame_err_now, is_break, par_err;

    uart_baud_tick #(
        .DIVIDER_WIDTH(DIVIDER_WIDTH)
    ) u_baud_tick (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .enable_i       (state != RX_IDLE),
        .clock_divider_i(clock_divider_i),
        .tick_o         (tick)
    );

    assign busy_o  = (state != RX_IDLE);
    assign bit_end = tick && (tick_cnt == TICK_LAST);
    assign bit_val = maj3(samples);

    always_comb begin
        len_clamped = data_bits_i;
        if (data_bits_i < 4'd5) begin
            len_clamped = 4'd5;
        end else if (data_bits_i > 4'(MAX_DATA_BITS)) begin
            len_clamped = 4'(MAX_DATA_BITS);
        end
    end

    assign last_stop      = (stop_q == UART_STOP1) || stop_cnt;
    assign first_stop_now = stop_cnt ? first_stop_q : bit_val;
    assign frame_err_now  = stop_err_q | ~bit_val;
    assign is_break       = (shift_q == '0) && (!par_en_q || !parity_bit_q) && !first_stop_now;
    assign par_err        = par_en_q && ((^shift_q ^ parity_bit_q) != (par_mode_q == UART_PARITY_ODD));

    // Start detection uses 'armed' (line seen high since the last bit boundary
    // of the previous frame) instead of a one-cycle edge strobe, so a start
    // bit that falls in the same cycle the last stop bit completes is not lost.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_meta        <= 1'b1;
            rx_sync        <= 1'b1;
            armed          <= 1'b0;
            state          <= RX_IDLE;
            tick_cnt       <= '0;
            samples        <= '0;
            bit_cnt        <= '0;
            stop_cnt       <= 1'b0;
            data_bits_q    <= 4'd8;
            par_en_q       <= 1'b0;
            par_mode_q     <= UART_PARITY_EVEN;
            stop_q         <= UART_STOP1;
            shift_q        <= '0;
            parity_bit_q   <= 1'b0;
            first_stop_q   <= 1'b0;
            stop_err_q     <= 1'b0;
            data_o         <= '0;
            valid_o        <= 1'b0;
            parity_error_o <= 1'b0;
            frame_error_o  <= 1'b0;
            overrun_o      <= 1'b0;
            break_o        <= 1'b0;
        end else begin
            rx_meta   <= rx_i;
            rx_sync   <= rx_meta;
            overrun_o <= 1'b0;
            break_o   <= 1'b0;
            if (rx_sync) armed <= 1'b1;
            if (valid_o && ready_i) valid_o <= 1'b0;

            if (tick) begin
                if (tick_cnt == SAMP_0) samples[0] <= rx_sync;
                if (tick_cnt == SAMP_1) samples[1] <= rx_sync;
                if (tick_cnt == SAMP_2) samples[2] <= rx_sync;
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            end

            if (state != RX_IDLE && !enable_i) begin
                state    <= RX_IDLE;
                tick_cnt <= '0;
                armed    <= rx_sync;
            end else begin
                unique case (state)
                    RX_IDLE: begin
                        tick_cnt <= '0;
                        if (enable_i && armed && !rx_sync) begin
                            state        <= RX_START;
                            armed        <= 1'b0;
                            data_bits_q  <= len_clamped;
                            par_en_q     <= parity_enable_i;
                            par_mode_q   <= uart_parity_mode_t'(parity_mode_i);
                            stop_q       <= uart_stop_bits_t'(stop_bits_i);
                            shift_q      <= '0;
                            bit_cnt      <= '0;
                            stop_cnt     <= 1'b0;
                            parity_bit_q <= 1'b0;
                            first_stop_q <= 1'b0;
                            stop_err_q   <= 1'b0;
                        end
                    end
                    RX_START: begin
                        if (bit_end) begin
                            armed <= rx_sync;
                            state <= bit_val ? RX_IDLE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (bit_end) begin
                            armed            <= rx_sync;
                            shift_q[bit_cnt] <= bit_val;
                            bit_cnt          <= bit_cnt + 4'd1;
                            if (bit_cnt == data_bits_q - 4'd1) begin
                                state <= par_en_q ? RX_PARITY : RX_STOP;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (bit_end) begin
                            armed        <= rx_sync;
                            parity_bit_q <= bit_val;
                            state        <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (bit_end) begin
                            stop_err_q <= frame_err_now;
                            if (!last_stop) begin
                                armed        <= rx_sync;
                                first_stop_q <= bit_val;
                                stop_cnt     <= 1'b1;
                            end else if (is_break) begin
                                break_o <= 1'b1;
                                state   <= RX_BREAK_WAIT;
                            end else begin
                                data_o         <= shift_q;
                                parity_error_o <= par_err;
                                frame_error_o  <= frame_err_now;
                                valid_o        <= 1'b1;
                                overrun_o      <= valid_o && !ready_i;
                                state          <= RX_IDLE;
                            end
                        end
                    end
                    RX_BREAK_WAIT: begin
                        // Needs a full bit time of continuous high line.
                        if (!rx_sync) begin
                            tick_cnt <= '0;
                        end else if (bit_end) begin
                            state <= RX_IDLE;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Parametrised UART receive engine; successor to the fixed 5–8 bit receive path.
- Adds configurable oversampling and 5–9 data bits.
- Adds 3-sample majority voting, framing-error and break detection, and a valid/ready output handshake with overrun flagging.
- Sits between the rx pin and the RX buffer of the UART peripheral; driven by fields of the UART status register.

Parameters:
- OVERSAMPLE, 16, oversample ticks per bit; even, ≥8.
- DIVIDER_WIDTH, 15, width of clock_divider_i.
- MAX_DATA_BITS, 9, width of data_o; supported lengths are 5..MAX_DATA_BITS.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous active-low reset
- enable_i  in  1  receiver enable (enable_RX)
- rx_i  in  1  asynchronous serial line, idle high
- clock_divider_i  in  DIVIDER_WIDTH  oversample tick every clock_divider_i+1 cycles
- data_bits_i  in  4  data length, 5..MAX_DATA_BITS
- parity_enable_i  in  1  expect parity bit
- parity_mode_i  in  1  uart_parity_mode_t (EVEN/ODD)
- stop_bits_i  in  1  uart_stop_bits_t (STOP1/STOP2)
- data_o  out  MAX_DATA_BITS  received word, LSB first on line, zero-extended
- valid_o  out  1  data_o/flags valid
- ready_i  in  1  consumer accepts word
- parity_error_o  out  1  qualified by valid_o
- frame_error_o  out  1  qualified by valid_o
- overrun_o  out  1  one-cycle pulse: frame completed while previous word unaccepted
- break_o  out  1  one-cycle pulse: break condition detected
- busy_o  out  1  frame in progress (state ≠ IDLE)

Behaviour:
- Reset (rst_n_i=0 at clk_i edge):
  - all outputs 0;
  - synchroniser flops reset to 1;
  - state IDLE;
  - counters cleared.
- Input synchronisation: rx_i passes through a 2-flop synchroniser. All references below use the synchronised value; it adds 2 cycles of latency.
- Tick generator:
  - DIVIDER_WIDTH counter; tick pulses when count == clock_divider_i, then count clears.
  - Divider 0 gives a tick every cycle.
  - Runs only when state ≠ IDLE; cleared in IDLE.
- Sampling:
  - tick counter 0..OVERSAMPLE-1 per bit.
  - Samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - Bit value = majority of the 3 samples, decided at the wrap of the tick counter.
- Config latching: data_bits_i, parity_*, stop_bits_i are latched on leaving IDLE. Changes mid-frame have no effect on the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: enable_i=1 and falling edge on line → START.
  - START: majority 1 → IDLE (glitch rejected, no flags); majority 0 → DATA.
  - DATA: shift in LSB first; after latched data_bits bits → PARITY if parity enabled, else STOP.
  - PARITY: check parity.
    - EVEN: XOR(data, parity bit) must be 0.
    - ODD: XOR(data, parity bit) must be 1.
    - Then → STOP.
  - STOP: 1 or 2 stop bits; any stop bit sampled 0 ⇒ frame error.
- Frame completion (end of last stop bit):
  - Break: data all 0, parity (if any) 0 and first stop bit 0 → break_o pulse, no valid, → BREAK_WAIT.
  - Otherwise:
    - data_o, parity_error_o, frame_error_o load;
    - valid_o=1 on the next cycle;
    - → IDLE.
  - STOP2 with first stop bit 1 and second stop bit 0 is a frame error, not a break.
- BREAK_WAIT: stay until line is 1 for one full bit time (OVERSAMPLE ticks), then → IDLE.
- Handshake:
  - valid_o holds with data stable until a cycle with valid_o && ready_i; it drops the next cycle.
  - New frame completing while valid_o=1 and ready_i=0:
    - overrun_o pulses;
    - old word is replaced by the new word;
    - valid_o stays 1.
  - Completion in the same cycle as acceptance: new word loads, valid_o stays 1, no overrun.
- enable_i=0: FSM → IDLE next cycle and any partial frame is discarded. valid_o and data_o are unaffected.
- Data width: bits at and above the latched data length are 0 in data_o.
- Reset mid-frame: immediate return to reset state; no flags.

Decomposition:
- uart_pkg additions:
  - uart_rx_state_t enum;
  - localparam UART_MAX_DATA_BITS = 9;
  - data-length type widened to 4 bits as uart_data_length_t (values 5..9), coexisting with the 2-bit legacy enum.
- Sub-module uart_baud_tick: tick generator, DIVIDER_WIDTH counter plus enable input. It is reused by the future parametrised transmitter.

Test Plan:
All scenarios use OVERSAMPLE=16 and divider=3, so one bit is 64 cycles.
- 8N1, send 0xA5, ready_i=1 → one valid_o cycle, data_o=0x0A5, no error flags, busy_o low after stop bit.
- 9 bits, even parity, STOP2, send 0x1FF with parity bit 1 → data_o=0x1FF, parity_error_o=0. Repeat with parity bit 0 → parity_error_o=1.
- 7E1, send 0x41 with stop bit forced 0 → valid_o=1, frame_error_o=1, data_o=0x041.
- Line low for 12 bit times (8E1 config) → break_o single pulse, no valid_o; the next frame 0x3C is received correctly only after the line has been high for ≥64 cycles.
- 20-cycle low glitch on idle line → START rejects it, no valid_o, busy_o returns 0.
- Two back-to-back frames 0x11, 0x22 with ready_i=0 → overrun_o pulses once, data_o=0x22. Raise ready_i → valid_o drops the next cycle.
